// File: rtl/pe_link_driver.sv
// rtl/pe_link_driver.sv - buffered driver for one PE neighbour link with delayed reply capture
module pe_link_driver #(
    parameter int ADDR_WIDTH  = 3,
    parameter int DATA_WIDTH  = 3,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 1,
    parameter int LATENCY     = 1,
    parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] IDLE_WORD = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] s_word,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_link,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_pe,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] m_word,
    output logic                             busy,
    output logic [7:0]                       o_count
);
    localparam int W    = ADDR_WIDTH + DATA_WIDTH;
    localparam int PW   = $clog2(DEPTH);
    localparam int CMAX = (HOLD_CYCLES > LATENCY) ? HOLD_CYCLES : LATENCY;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] LAT_LOAD  = CW'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_OUT} state_t;

    state_t        state_q;
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   occ_q;
    logic [PW:0]   occ_d;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  o_link_q;
    logic          m_valid_q;
    logic [W-1:0]  m_word_q;
    logic [7:0]    count_q;
    logic          full;
    logic          push;
    logic          pop;

    assign full = (occ_q == (PW+1)'(DEPTH));
    assign push = s_valid && !full;
    // The FSM is the only consumer, and it only takes a word when no transaction is in flight.
    assign pop  = (state_q == S_IDLE) && (occ_q != '0);

    always_comb begin
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + (PW+1)'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            occ_q <= occ_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            o_link_q  <= IDLE_WORD;
            m_valid_q <= 1'b0;
            m_word_q  <= '0;
            count_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        o_link_q <= mem_q[rd_ptr_q];
                        cnt_q    <= HOLD_LOAD;
                        state_q  <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == '0) begin
                        o_link_q <= IDLE_WORD;
                        cnt_q    <= LAT_LOAD;
                        state_q  <= S_WAIT;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        m_word_q  <= i_pe;
                        m_valid_q <= 1'b1;
                        state_q   <= S_OUT;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_OUT: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        count_q   <= count_q + 8'd1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign s_ready = !full;
    assign o_link  = o_link_q;
    assign m_valid = m_valid_q;
    assign m_word  = m_word_q;
    assign o_count = count_q;
    assign busy    = (state_q != S_IDLE) || (occ_q != '0);
endmodule

// File: tb/tb_pe_link_driver.sv
// tb/tb_pe_link_driver.sv - randomized bench for pe_link_driver against a transaction-timing model
module tb_pe_link_driver;
    logic       clk;
    logic       rst;
    logic       sv     [2];
    logic [5:0] sw     [2];
    logic       mr     [2];
    logic [5:0] ipe    [2];
    logic       srdy   [2];
    logic [5:0] olink  [2];
    logic       mvalid [2];
    logic [5:0] mword  [2];
    logic       busy_w [2];
    logic [7:0] ocnt   [2];

    int n_check = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    int         pe_mode [2];
    logic [5:0] pe_val  [2];
    logic [5:0] pe_lat  [2];
    bit         collect;
    logic [5:0] gotq [$];

    // Model: accepted words in a ring, plus the edge number at which the current word was popped.
    logic [5:0] mq [2][1024];
    int         mh [2];
    int         mt [2];
    bit         act [2];
    logic [5:0] cur [2];
    int         st  [2];
    bit         mv  [2];
    logic [5:0] mw  [2];
    logic [7:0] cnt [2];

    pe_link_driver u_dut0 (
        .clk(clk), .rst(rst), .s_valid(sv[0]), .s_ready(srdy[0]), .s_word(sw[0]),
        .o_link(olink[0]), .i_pe(ipe[0]), .m_valid(mvalid[0]), .m_ready(mr[0]),
        .m_word(mword[0]), .busy(busy_w[0]), .o_count(ocnt[0])
    );

    pe_link_driver #(.HOLD_CYCLES(3), .LATENCY(2)) u_dut1 (
        .clk(clk), .rst(rst), .s_valid(sv[1]), .s_ready(srdy[1]), .s_word(sw[1]),
        .o_link(olink[1]), .i_pe(ipe[1]), .m_valid(mvalid[1]), .m_ready(mr[1]),
        .m_word(mword[1]), .busy(busy_w[1]), .o_count(ocnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int hold_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_check++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mh[k] = 0; mt[k] = 0; act[k] = 0; cur[k] = '0; st[k] = 0;
            mv[k] = 0; mw[k] = '0; cnt[k] = '0;
        end
    endtask

    task automatic model_step(input int k);
        int sz;
        bit acc;
        sz  = mt[k] - mh[k];
        acc = sv[k] && (sz < 4);
        if (act[k]) begin
            if (mv[k] && mr[k]) begin
                mv[k] = 0; act[k] = 0; cnt[k] = cnt[k] + 8'd1;
            end else if (edge_n == st[k] + hold_of(k) + lat_of(k)) begin
                mv[k] = 1; mw[k] = ipe[k];
            end
        end else if (sz != 0) begin
            cur[k] = mq[k][mh[k] % 1024]; mh[k]++; act[k] = 1; st[k] = edge_n;
        end
        if (acc) begin
            mq[k][mt[k] % 1024] = sw[k]; mt[k]++;
        end
    endtask

    task automatic compare(input int k);
        logic [5:0] exp_link;
        int sz;
        sz = mt[k] - mh[k];
        exp_link = (act[k] && edge_n >= st[k] && edge_n < st[k] + hold_of(k)) ? cur[k] : 6'd0;
        chk($sformatf("i%0d_link", k), 32'(olink[k]), 32'(exp_link));
        chk($sformatf("i%0d_mvalid", k), 32'(mvalid[k]), 32'(mv[k]));
        chk($sformatf("i%0d_mword", k), 32'(mword[k]), 32'(mw[k]));
        chk($sformatf("i%0d_sready", k), 32'(srdy[k]), 32'(sz < 4));
        chk($sformatf("i%0d_busy", k), 32'(busy_w[k]), 32'(act[k] || sz != 0));
        chk($sformatf("i%0d_count", k), 32'(ocnt[k]), 32'(cnt[k]));
    endtask

    always @(negedge rst) model_reset();

    always @(posedge clk) begin
        edge_n++;
        if (collect && mvalid[0] && mr[0]) gotq.push_back(mword[0]);
        if (rst) begin
            model_step(0);
            model_step(1);
        end
        #1;
        compare(0);
        compare(1);
    end

    // PE stand-in: fixed value, random per cycle, or echo of the last word driven on the link.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            case (pe_mode[k])
                0: ipe[k] = pe_val[k];
                1: ipe[k] = 6'($urandom);
                default: begin
                    if (olink[k] != 6'd0) pe_lat[k] = olink[k];
                    ipe[k] = pe_lat[k];
                end
            endcase
        end
    end

    task automatic push_word(input int k, input logic [5:0] w);
        int guard;
        guard = 0;
        sv[k] = 1'b1;
        sw[k] = w;
        while (!srdy[k] && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk($sformatf("i%0d_push_timeout", k), 32'(guard < 300), 32'd1);
        @(negedge clk);
        sv[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int guard;
        guard = 0;
        while (busy_w[k] && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        chk($sformatf("i%0d_idle_timeout", k), 32'(guard < 3000), 32'd1);
    endtask

    initial begin
        logic [5:0] cap;
        logic [5:0] hlw;
        int mv_seen;
        rst = 1'b0;
        collect = 0;
        for (int k = 0; k < 2; k++) begin
            sv[k] = 0; sw[k] = '0; mr[k] = 0; pe_mode[k] = 0; pe_val[k] = '0; pe_lat[k] = '0;
            ipe[k] = '0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("rst_link", 32'(olink[k]), 32'd0);
            chk("rst_mvalid", 32'(mvalid[k]), 32'd0);
            chk("rst_sready", 32'(srdy[k]), 32'd1);
            chk("rst_busy", 32'(busy_w[k]), 32'd0);
            chk("rst_count", 32'(ocnt[k]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        mr[0] = 1; pe_val[0] = 6'b000010;
        @(negedge clk); sv[0] = 1; sw[0] = 6'b000010;
        @(negedge clk); sv[0] = 0;
        @(posedge clk); #2 chk("t1_link_on", 32'(olink[0]), 32'd2);
        @(posedge clk); #2 chk("t1_link_off", 32'(olink[0]), 32'd0);
        chk("t1_mvalid_early", 32'(mvalid[0]), 32'd0);
        @(posedge clk); #2 chk("t1_mvalid", 32'(mvalid[0]), 32'd1);
        chk("t1_mword", 32'(mword[0]), 32'd2);
        @(posedge clk); #2 chk("t1_mvalid_pulse", 32'(mvalid[0]), 32'd0);
        chk("t1_count", 32'(ocnt[0]), 32'd1);

        @(negedge clk);
        mr[0] = 0; pe_mode[0] = 2; collect = 1; gotq.delete();
        for (int w = 1; w <= 5; w++) push_word(0, 6'(w));
        sv[0] = 1; sw[0] = 6'd6;
        chk("bp_full", 32'(srdy[0]), 32'd0);
        repeat (4) @(negedge clk);
        chk("bp_still_full", 32'(srdy[0]), 32'd0);
        chk("bp_reply_waiting", 32'(mvalid[0]), 32'd1);
        mr[0] = 1;
        push_word(0, 6'd6);
        wait_idle(0);
        collect = 0;
        chk("bp_reply_cnt", 32'(gotq.size()), 32'd6);
        for (int i = 0; i < gotq.size(); i++) chk("bp_order", 32'(gotq[i]), 32'(i + 1));
        chk("bp_count", 32'(ocnt[0]), 32'd7);

        mr[1] = 1; pe_mode[1] = 1;
        sv[1] = 1; sw[1] = 6'd11;
        @(negedge clk); sw[1] = 6'd12;
        @(negedge clk); sw[1] = 6'd13;
        @(negedge clk); sv[1] = 0;
        chk("mr_pre_link", 32'(olink[1]), 32'd11);
        #2 rst = 1'b0;
        #1;
        chk("mr_link_async", 32'(olink[1]), 32'd0);
        chk("mr_mvalid_async", 32'(mvalid[1]), 32'd0);
        chk("mr_busy_async", 32'(busy_w[1]), 32'd0);
        chk("mr_sready_async", 32'(srdy[1]), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mv_seen = 0;
        repeat (20) begin
            @(posedge clk);
            #2 if (mvalid[1]) mv_seen++;
        end
        chk("mr_no_mvalid", 32'(mv_seen), 32'd0);
        chk("mr_empty", 32'(busy_w[1]), 32'd0);

        @(negedge clk);
        pe_mode[0] = 1; mr[0] = 1;
        for (int i = 0; i < 256; i++) push_word(0, 6'($urandom_range(1, 63)));
        wait_idle(0);
        chk("wrap_count", 32'(ocnt[0]), 32'd0);
        chk("wrap_busy", 32'(busy_w[0]), 32'd0);

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                pe_mode[k] = 1;
                sv[k] = 1'($urandom_range(0, 1));
                sw[k] = 6'($urandom);
                mr[k] = ($urandom_range(0, 3) != 0);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sv[k] = 0; mr[k] = 1;
        end
        wait_idle(0);
        wait_idle(1);

        mr[1] = 0; pe_mode[1] = 1;
        hlw = 6'($urandom_range(1, 63));
        sv[1] = 1; sw[1] = hlw;
        @(posedge clk);
        @(negedge clk); sv[1] = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2 chk("hl_link_held", 32'(olink[1]), 32'(hlw));
        end
        @(posedge clk); #2 chk("hl_link_off", 32'(olink[1]), 32'd0);
        @(posedge clk); #2 chk("hl_mvalid_early", 32'(mvalid[1]), 32'd0);
        @(posedge clk);
        cap = ipe[1];
        #2 chk("hl_mvalid", 32'(mvalid[1]), 32'd1);
        chk("hl_capture", 32'(mword[1]), 32'(cap));
        repeat (3) begin
            @(posedge clk); #2 chk("hl_mword_stable", 32'(mword[1]), 32'(cap));
        end
        @(negedge clk); mr[1] = 1;
        wait_idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_check, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_check, n_fail);
        $finish;
    end
endmodule
